trap_sequencer: RTL and testbench

Sequential trap controller that sits directly downstream of the exception verifier. It consumes `exception`, `interrup` and the packed `excep_info` word, and owns the machine CSRs `mstatus`, `mtvec`, `mepc` and `mcause`. It redirects the PC to the trap vector and flushes the pipeline on trap entry, then restores state and redirects back on `mret`. Its `mstatus_o` feeds the verifier's `mstatus` input, closing the enable loop.

---
 rtl/trap_if.sv | 27 ++
 rtl/trap_sequencer.sv | 145 ++++++++++++++
 tb/tb_trap_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/trap_if.sv
// Trap-sequencer bus: verifier/pipeline inputs, CSR access port and redirect/flush outputs.
// master = verifier and pipeline side, slave = trap_sequencer.
interface trap_if;
    logic        exception;
    logic        interrup;
    logic [31:0] excep_info;
    logic        mret_i;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] mstatus_o;
    logic        pc_redirect;
    logic [15:0] redirect_addr;
    logic        flush;
    logic        in_trap;

    modport master (
        output exception, interrup, excep_info, mret_i, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, mstatus_o, pc_redirect, redirect_addr, flush, in_trap
    );

    modport slave (
        input  exception, interrup, excep_info, mret_i, csr_we, csr_addr, csr_wdata,
        output csr_rdata, mstatus_o, pc_redirect, redirect_addr, flush, in_trap
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: owns mstatus/mtvec/mepc/mcause, redirects on trap entry and mret.
// Optional TRAP_SEQ_COUNT_EN adds a trap counter port and read-only CSR 0xB03.
module trap_sequencer #(
    parameter logic [15:0] TRAP_VECTOR = 16'h01c0,
    parameter bit          RET_SKIP    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef TRAP_SEQ_COUNT_EN
    output logic [31:0] trap_count,
`endif
    trap_if.slave       bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = 16;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_COUNT   = 12'hB03;

    localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(1);

    typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_t;

    state_t          state;
    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
    logic            pc_redirect_q, flush_q, in_trap_q;
    logic [PCW-1:0]  redirect_addr_q;
    logic [XLEN-1:0] count_rd;

    logic            wr_mstatus, wr_mtvec, wr_mepc, wr_mcause;
    logic            trap_req;
    logic [PCW-1:0]  mtvec_nxt, mepc_nxt, ret_addr;
    logic            cause_irq_nxt;

    // Write decode and the values the redirect target will see after this edge's CSR write.
    always_comb begin
        wr_mstatus    = bus.csr_we && (bus.csr_addr == ADDR_MSTATUS);
        wr_mtvec      = bus.csr_we && (bus.csr_addr == ADDR_MTVEC);
        wr_mepc       = bus.csr_we && (bus.csr_addr == ADDR_MEPC);
        wr_mcause     = bus.csr_we && (bus.csr_addr == ADDR_MCAUSE);
        trap_req      = (bus.exception || bus.interrup) && (mstatus == MSTATUS_RST);
        mtvec_nxt     = wr_mtvec  ? {bus.csr_wdata[PCW-1:2], 2'b00} : mtvec[PCW-1:0];
        mepc_nxt      = wr_mepc   ? bus.csr_wdata[PCW-1:0] : mepc[PCW-1:0];
        cause_irq_nxt = wr_mcause ? bus.csr_wdata[XLEN-1] : mcause[XLEN-1];
        ret_addr      = (RET_SKIP && !cause_irq_nxt) ? mepc_nxt + PCW'(4) : mepc_nxt;
    end

    // FSM, CSRs and registered outputs; hardware updates are written last so they win over csr_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mstatus         <= MSTATUS_RST;
            mtvec           <= {16'h0, TRAP_VECTOR};
            mepc            <= '0;
            mcause          <= '0;
            pc_redirect_q   <= 1'b0;
            flush_q         <= 1'b0;
            in_trap_q       <= 1'b0;
            redirect_addr_q <= '0;
        end else begin
            if (wr_mstatus) mstatus <= bus.csr_wdata;
            if (wr_mtvec)   mtvec   <= {bus.csr_wdata[XLEN-1:2], 2'b00};
            if (wr_mepc)    mepc    <= bus.csr_wdata;
            if (wr_mcause)  mcause  <= bus.csr_wdata;

            pc_redirect_q   <= 1'b0;
            flush_q         <= 1'b0;
            in_trap_q       <= 1'b0;
            redirect_addr_q <= '0;

            case (state)
                IDLE: begin
                    if (trap_req) begin
                        mepc            <= {16'h0, bus.excep_info[15:0]};
                        mcause          <= {bus.excep_info[31], 24'h0, bus.excep_info[30:24]};
                        mstatus         <= {24'h0, bus.excep_info[23:16]};
                        state           <= ENTER;
                        pc_redirect_q   <= 1'b1;
                        flush_q         <= 1'b1;
                        redirect_addr_q <= mtvec_nxt;
                    end
                end
                ENTER: begin
                    state     <= HANDLER;
                    in_trap_q <= 1'b1;
                end
                HANDLER: begin
                    if (bus.mret_i) begin
                        state           <= RETURN;
                        pc_redirect_q   <= 1'b1;
                        flush_q         <= 1'b1;
                        redirect_addr_q <= ret_addr;
                    end else begin
                        in_trap_q <= 1'b1;
                    end
                end
                RETURN: begin
                    mstatus <= MSTATUS_RST;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRAP_SEQ_COUNT_EN
    logic [XLEN-1:0] count_q;

    // Counts IDLE->ENTER transitions; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if ((state == IDLE) && trap_req) begin
            count_q <= count_q + XLEN'(1);
        end
    end

    assign trap_count = count_q;
    assign count_rd   = count_q;
`else
    assign count_rd   = '0;
`endif

    // Combinational CSR read port.
    always_comb begin
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: bus.csr_rdata = mstatus;
            ADDR_MTVEC:   bus.csr_rdata = mtvec;
            ADDR_MEPC:    bus.csr_rdata = mepc;
            ADDR_MCAUSE:  bus.csr_rdata = mcause;
            ADDR_COUNT:   bus.csr_rdata = count_rd;
            default:      bus.csr_rdata = '0;
        endcase
    end

    assign bus.mstatus_o     = mstatus;
    assign bus.pc_redirect   = pc_redirect_q;
    assign bus.flush         = flush_q;
    assign bus.in_trap       = in_trap_q;
    assign bus.redirect_addr = redirect_addr_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: vector table plus hand-written reset/counter sequences.
// Each step drives inputs on the falling edge and checks outputs just after the rising edge.
module tb_trap_sequencer;
    logic clk;
    logic rst;
    trap_if bus ();

`ifdef TRAP_SEQ_COUNT_EN
    logic [31:0] trap_count;
`endif

    trap_sequencer dut (
        .clk        (clk),
        .rst        (rst),
`ifdef TRAP_SEQ_COUNT_EN
        .trap_count (trap_count),
`endif
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        exc;
        logic        irq;
        logic [31:0] info;
        logic        mret;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        redir;
        logic        flush;
        logic        in_trap;
        logic [15:0] raddr;
        logic [31:0] mstatus;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    function automatic vec_t mk(logic r, logic e, logic i, logic [31:0] inf, logic m,
                                logic w, logic [11:0] a, logic [31:0] wd,
                                logic xr, logic xf, logic xt, logic [15:0] xa,
                                logic [31:0] xs, logic [31:0] xd);
        vec_t v;
        v.rst = r; v.exc = e; v.irq = i; v.info = inf; v.mret = m;
        v.we = w; v.addr = a; v.wdata = wd;
        v.redir = xr; v.flush = xf; v.in_trap = xt; v.raddr = xa;
        v.mstatus = xs; v.rdata = xd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step_no, act, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then pop and compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst            = v.rst;
        bus.exception  = v.exc;
        bus.interrup   = v.irq;
        bus.excep_info = v.info;
        bus.mret_i     = v.mret;
        bus.csr_we     = v.we;
        bus.csr_addr   = v.addr;
        bus.csr_wdata  = v.wdata;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pc_redirect",   32'(bus.pc_redirect),   32'(e.redir));
        chk("flush",         32'(bus.flush),         32'(e.flush));
        chk("in_trap",       32'(bus.in_trap),       32'(e.in_trap));
        chk("redirect_addr", 32'(bus.redirect_addr), 32'(e.raddr));
        chk("mstatus_o",     bus.mstatus_o,          e.mstatus);
        chk("csr_rdata",     bus.csr_rdata,          e.rdata);
        step_no++;
    endtask

    initial begin
        logic [31:0] cnt_exp;
        rst = 1'b1;
        bus.exception = 1'b0; bus.interrup = 1'b0; bus.excep_info = '0; bus.mret_i = 1'b0;
        bus.csr_we = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0;

        //              rst exc irq info          mret we addr    wdata         rdr fl  it  raddr     mstatus  rdata
        tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 12'h305, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h1c0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h305, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h1c0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h341, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'hB03, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h0));
        // illegal instruction trap, nested exception blocked, return to mepc+4
        tbl.push_back(mk(0, 1, 0, 32'h02100040,  0, 0, 12'h342, 32'h0,        1, 1, 0, 16'h01c0, 32'h10, 32'h2));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h341, 32'h0,        0, 0, 1, 16'h0000, 32'h10, 32'h40));
        tbl.push_back(mk(0, 1, 0, 32'h05200080,  0, 0, 12'h342, 32'h0,        0, 0, 1, 16'h0000, 32'h10, 32'h2));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h341, 32'h0,        0, 0, 1, 16'h0000, 32'h10, 32'h40));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 12'h300, 32'h0,        1, 1, 0, 16'h0044, 32'h10, 32'h10));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h300, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h1));
        // interrupt: return to mepc exactly
        tbl.push_back(mk(0, 0, 1, 32'h80100020,  0, 0, 12'h342, 32'h0,        1, 1, 0, 16'h01c0, 32'h10, 32'h80000000));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h341, 32'h0,        0, 0, 1, 16'h0000, 32'h10, 32'h20));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 12'h300, 32'h0,        1, 1, 0, 16'h0020, 32'h10, 32'h10));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h300, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h1));
        // mret in IDLE ignored; mtvec low bits forced to zero
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 12'h341, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h20));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 1, 12'h305, 32'h103,      0, 0, 0, 16'h0000, 32'h1,  32'h100));
        // trap beats same-edge mepc write; mret in ENTER ignored; handler rewrites mepc
        tbl.push_back(mk(0, 1, 0, 32'h03100060,  0, 1, 12'h341, 32'hdead,     1, 1, 0, 16'h0100, 32'h10, 32'h60));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 12'h341, 32'h0,        0, 0, 1, 16'h0000, 32'h10, 32'h60));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 1, 12'h341, 32'h200,      0, 0, 1, 16'h0000, 32'h10, 32'h200));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 12'h341, 32'h0,        1, 1, 0, 16'h0204, 32'h10, 32'h200));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h300, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h1));
        // return address wraps modulo 2^16
        tbl.push_back(mk(0, 1, 0, 32'h0210fffc,  0, 0, 12'h341, 32'h0,        1, 1, 0, 16'h0100, 32'h10, 32'hfffc));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h341, 32'h0,        0, 0, 1, 16'h0000, 32'h10, 32'hfffc));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 12'h341, 32'h0,        1, 1, 0, 16'h0000, 32'h10, 32'hfffc));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 12'h300, 32'h0,        0, 0, 0, 16'h0000, 32'h1,  32'h1));
        // mstatus other than exactly 1 disables trap entry
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 1, 12'h300, 32'h3,        0, 0, 0, 16'h0000, 32'h3,  32'h3));
        tbl.push_back(mk(0, 1, 0, 32'h05100040,  0, 0, 12'h342, 32'h0,        0, 0, 0, 16'h0000, 32'h3,  32'h2));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 1, 12'h300, 32'h1,        0, 0, 0, 16'h0000, 32'h1,  32'h1));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset during ENTER drops the redirect and restores all CSRs.
        step(mk(0, 1, 0, 32'h02100040, 0, 0, 12'h341, 32'h0, 1, 1, 0, 16'h0100, 32'h10, 32'h40));
        step(mk(1, 0, 0, 32'h0,        0, 0, 12'h341, 32'h0, 0, 0, 0, 16'h0000, 32'h1,  32'h0));
        step(mk(0, 0, 0, 32'h0,        0, 0, 12'h305, 32'h0, 0, 0, 0, 16'h0000, 32'h1,  32'h1c0));

        // Three complete traps for the optional counter.
        for (int t = 0; t < 3; t++) begin
            step(mk(0, 1, 0, 32'h02100040, 0, 0, 12'h342, 32'h0, 1, 1, 0, 16'h01c0, 32'h10, 32'h2));
            step(mk(0, 0, 0, 32'h0,        0, 0, 12'h341, 32'h0, 0, 0, 1, 16'h0000, 32'h10, 32'h40));
            step(mk(0, 0, 0, 32'h0,        1, 0, 12'h341, 32'h0, 1, 1, 0, 16'h0044, 32'h10, 32'h40));
            step(mk(0, 0, 0, 32'h0,        0, 0, 12'h300, 32'h0, 0, 0, 0, 16'h0000, 32'h1,  32'h1));
        end
`ifdef TRAP_SEQ_COUNT_EN
        cnt_exp = 32'd3;
`else
        cnt_exp = 32'd0;
`endif
        // Write to 0xB03 is ignored; read returns the count (or 0 without the counter).
        step(mk(0, 0, 0, 32'h0, 0, 1, 12'hB03, 32'h55, 0, 0, 0, 16'h0000, 32'h1, cnt_exp));
`ifdef TRAP_SEQ_COUNT_EN
        chk("trap_count", trap_count, cnt_exp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
